// File: rtl/round_robin_tester_pkg.sv
// Shared sizing constants and the circular-increment helper used by the
// round-robin arbiter and its cross-check.
package round_robin_tester_pkg;

    localparam int QUEUE_QUANTITY = 4;
    localparam int DATA_BITS      = 8;
    localparam int SEL_BITS       = $clog2(QUEUE_QUANTITY);

    // Next index in circular order; qq is the number of queues.
    function automatic int circ_inc(input int idx, input int qq);
        return (idx + 1) % qq;
    endfunction

endpackage

// File: rtl/round_robin_tester_if.sv
// Bundle of arbitration inputs and the two arbiters' registered results.
interface round_robin_tester_if #(
    parameter int QUEUE_QUANTITY = round_robin_tester_pkg::QUEUE_QUANTITY,
    parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY)
);
    logic                      enb;
    logic [QUEUE_QUANTITY-1:0] buf_empty;
    logic [SEL_BITS-1:0]       selector;
    logic                      selector_enb;
    logic [SEL_BITS-1:0]       sint_selector;
    logic                      sint_selector_enb;
    logic                      mismatch;

    modport master (
        output enb, buf_empty,
        input  selector, selector_enb, sint_selector, sint_selector_enb, mismatch
    );

    modport slave (
        input  enb, buf_empty,
        output selector, selector_enb, sint_selector, sint_selector_enb, mismatch
    );
endinterface

// File: rtl/round_robin_core.sv
// Reference round-robin arbiter: behavioural circular scan starting one
// past the current grant and ending on the current grant itself.
module round_robin_core #(
    parameter int QUEUE_QUANTITY = round_robin_tester_pkg::QUEUE_QUANTITY,
    parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic [QUEUE_QUANTITY-1:0] buf_empty,
    output logic [SEL_BITS-1:0]       selector,
    output logic                      selector_enb
);
    import round_robin_tester_pkg::*;

    logic [SEL_BITS-1:0] next_sel;
    logic                found;
    logic [SEL_BITS-1:0] idx_sel;
    int                  idx;

    always_comb begin
        next_sel = selector;
        found    = 1'b0;
        idx      = int'(selector);
        idx_sel  = selector;
        for (int k = 0; k < QUEUE_QUANTITY; k++) begin
            idx     = circ_inc(idx, QUEUE_QUANTITY);
            idx_sel = SEL_BITS'(idx);
            if (!found && !buf_empty[idx_sel]) begin
                next_sel = idx_sel;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            selector     <= '0;
            selector_enb <= 1'b0;
        end else if (enb) begin
            selector     <= next_sel;
            selector_enb <= found;
        end
    end

endmodule

// File: rtl/round_robin_tester.sv
// Round-robin arbiter with an independently coded rotate/priority-encode
// twin; a registered flag reports any disagreement between the two.
module round_robin_tester #(
    parameter int QUEUE_QUANTITY = round_robin_tester_pkg::QUEUE_QUANTITY,
    parameter int DATA_BITS      = round_robin_tester_pkg::DATA_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    round_robin_tester_if.slave     bus
);
    import round_robin_tester_pkg::*;

    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    if (QUEUE_QUANTITY < 2 || (QUEUE_QUANTITY & (QUEUE_QUANTITY - 1)) != 0 || DATA_BITS < 1)
    begin : g_param_check
        $error("round_robin_tester: QUEUE_QUANTITY must be a power of two >= 2");
    end

    logic [SEL_BITS-1:0] ref_sel;
    logic                ref_enb;

    round_robin_core #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .SEL_BITS       (SEL_BITS)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .enb          (bus.enb),
        .buf_empty    (bus.buf_empty),
        .selector     (ref_sel),
        .selector_enb (ref_enb)
    );

    logic [SEL_BITS-1:0]         sint_sel;
    logic                        sint_enb;
    logic                        mis;
    logic [SEL_BITS-1:0]         shift;
    logic [SEL_BITS-1:0]         offset;
    logic [SEL_BITS-1:0]         sint_next;
    logic [2*QUEUE_QUANTITY-1:0] dbl;
    logic [QUEUE_QUANTITY-1:0]   rot;
    logic [QUEUE_QUANTITY-1:0]   avail;
    logic [QUEUE_QUANTITY-1:0]   lowest;

    // Rotate so bit 0 is the queue after the current grant, isolate the
    // lowest non-empty bit, encode it, then rotate the index back.
    always_comb begin
        shift  = sint_sel + SEL_BITS'(1);
        dbl    = {bus.buf_empty, bus.buf_empty};
        rot    = dbl[shift +: QUEUE_QUANTITY];
        avail  = ~rot;
        lowest = avail & (~avail + QUEUE_QUANTITY'(1));
        offset = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (lowest[i]) begin
                offset = offset | SEL_BITS'(i);
            end
        end
        sint_next = shift + offset;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sint_sel <= '0;
            sint_enb <= 1'b0;
            mis      <= 1'b0;
        end else if (bus.enb) begin
            if (|avail) begin
                sint_sel <= sint_next;
            end
            sint_enb <= |avail;
            mis      <= ({ref_sel, ref_enb} != {sint_sel, sint_enb});
        end
    end

    assign bus.selector          = ref_sel;
    assign bus.selector_enb      = ref_enb;
    assign bus.sint_selector     = sint_sel;
    assign bus.sint_selector_enb = sint_enb;
    assign bus.mismatch          = mis;

endmodule

// File: tb/tb_round_robin_tester.sv
// Directed and random stimulus for round_robin_tester with a queued
// scoreboard of expected grants.
module tb_round_robin_tester;

    localparam int QQ = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic       enb;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];
    logic [1:0] m_sel;
    logic       m_enb;

    round_robin_tester_if #(.QUEUE_QUANTITY(QQ)) bus();

    round_robin_tester #(.QUEUE_QUANTITY(QQ), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bench-side arbiter model: scan cur+1 .. cur+QQ modulo QQ.
    task automatic model(input logic r, input logic e, input logic [3:0] be);
        logic       hit;
        logic [1:0] pick;
        hit  = 1'b0;
        pick = m_sel;
        for (int k = QQ; k >= 1; k--) begin
            if (!be[(int'(m_sel) + k) % QQ]) begin
                hit  = 1'b1;
                pick = 2'((int'(m_sel) + k) % QQ);
            end
        end
        if (!r) begin
            m_sel = 2'd0;
            m_enb = 1'b0;
        end else if (e) begin
            m_sel = pick;
            m_enb = hit;
        end
    endtask

    // xs/xe < 0 means take the expectation from the model.
    task automatic step(input logic r, input logic e, input logic [3:0] be,
                        input int xs, input int xe);
        exp_t x;
        @(negedge clk);
        rst           = r;
        bus.enb       = e;
        bus.buf_empty = be;
        model(r, e, be);
        x.sel = (xs < 0) ? m_sel : 2'(xs);
        x.enb = (xe < 0) ? m_enb : 1'(xe);
        sb.push_back(x);
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() == 1) else begin
            bad++;
            $error("FAIL sb_depth observed=%0d expected=1", sb.size());
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("selector",          8'(bus.selector),          8'(x.sel));
            chk("selector_enb",      8'(bus.selector_enb),      8'(x.enb));
            chk("sint_selector",     8'(bus.sint_selector),     8'(x.sel));
            chk("sint_selector_enb", 8'(bus.sint_selector_enb), 8'(x.enb));
            chk("mismatch",          8'(bus.mismatch),          8'd0);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        m_sel         = 2'd0;
        m_enb         = 1'b0;
        rst           = 1'b0;
        bus.enb       = 1'b0;
        bus.buf_empty = 4'b0000;

        step(1'b0, 1'b0, 4'b0000, 0, 0);
        step(1'b0, 1'b1, 4'b0000, 0, 0);

        // Free-running rotation from reset starts at index 1.
        step(1'b1, 1'b1, 4'b0000, 1, 1);
        step(1'b1, 1'b1, 4'b0000, 2, 1);
        step(1'b1, 1'b1, 4'b0000, 3, 1);
        step(1'b1, 1'b1, 4'b0000, 0, 1);
        step(1'b1, 1'b1, 4'b0000, 1, 1);
        step(1'b1, 1'b1, 4'b0000, 2, 1);
        step(1'b1, 1'b1, 4'b0000, 3, 1);

        // Wrap past empty queues 0 and 1.
        step(1'b1, 1'b1, 4'b0011, 2, 1);
        step(1'b1, 1'b1, 4'b0000, 3, 1);

        // All empty: hold, then resume from the held index.
        step(1'b1, 1'b1, 4'b1111, 3, 0);
        step(1'b1, 1'b1, 4'b0000, 0, 1);

        // Skip queue 3.
        step(1'b1, 1'b1, 4'b0000, 1, 1);
        step(1'b1, 1'b1, 4'b1000, 2, 1);
        step(1'b1, 1'b1, 4'b1000, 0, 1);
        step(1'b1, 1'b1, 4'b1000, 1, 1);

        // Only the current grant is non-empty: it is re-granted last.
        step(1'b1, 1'b1, 4'b1101, 1, 1);

        // Freeze with changing inputs.
        step(1'b1, 1'b0, 4'b0101, 1, 1);
        step(1'b1, 1'b0, 4'b1110, 1, 1);
        step(1'b1, 1'b0, 4'b1111, 1, 1);

        // Mid-rotation reset with enb high, then resume at index 1.
        step(1'b1, 1'b1, 4'b0000, 2, 1);
        step(1'b0, 1'b1, 4'b0000, 0, 0);
        step(1'b1, 1'b1, 4'b0000, 1, 1);

        for (int n = 0; n < 1000; n++) begin
            logic [3:0] be;
            logic       e;
            be = 4'($urandom);
            if ($urandom_range(0, 15) == 0) be = 4'b1111;
            e  = ($urandom_range(0, 9) != 0);
            step(1'b1, e, be, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
